// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: arms on a start pulse, captures depth_q ADC (or ramp) samples into memory, then waits in DONE.
module adc_capture_ctrl #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              capture_start,
  input  logic              capture_again,
  input  logic [1:0]        pkt_data_length,
  input  logic              self_test_mode,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              capture_busy,
  output logic              capture_done,
  output logic [7:0]        capture_cnt
);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] idx, depth_q;
  logic take, last, relatch, arm_go;
  always_comb begin
    take      = (state == ARM || state == CAPTURE) && adc_valid;
    last      = take && idx == depth_q - ADDR_W'(1);
    relatch   = capture_start && (state == IDLE || state == DONE);
    arm_go    = relatch || (state == DONE && capture_again);
    state_nxt = arm_go ? ARM : last ? DONE : (state == ARM && adc_valid) ? CAPTURE : state;
  end
  // idx doubles as the ramp value; it clears on every entry into ARM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      idx         <= '0;
      depth_q     <= ADDR_W'(216);
      mem_wen     <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      capture_cnt <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= arm_go ? '0 : take ? idx + ADDR_W'(1) : idx;
      mem_wen <= take;
      if (relatch) depth_q <= ADDR_W'(216) << pkt_data_length;
      if (take) begin
        mem_waddr <= idx;
        mem_wdata <= self_test_mode ? DATA_W'(idx) : adc_data;
      end
      if (last) capture_cnt <= capture_cnt + 8'd1;
    end
  end
  assign capture_busy = state == ARM || state == CAPTURE;
  assign capture_done = state == DONE;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed scenarios with random data/valid, checked against a sample-counting reference model.
module tb_adc_capture_ctrl;
  localparam int DW = 18, AW = 11;
  logic clk = 0, rstn = 0;
  logic [DW-1:0] adc_data = '0;
  logic adc_valid = 0, capture_start = 0, capture_again = 0, self_test_mode = 0;
  logic [1:0] pkt_data_length = 0;
  logic mem_wen, capture_busy, capture_done;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [7:0] capture_cnt;
  int vectors = 0, errors = 0, wr_cnt = 0;
  bit m_busy = 0, m_done = 0;
  int m_n = 0, m_depth = 216, m_cnt = 0, e_addr = 0;
  logic e_wen;
  logic [DW-1:0] e_data;

  always #5 clk = ~clk;

  adc_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .adc_data(adc_data), .adc_valid(adc_valid),
    .capture_start(capture_start), .capture_again(capture_again),
    .pkt_data_length(pkt_data_length), .self_test_mode(self_test_mode),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .capture_busy(capture_busy), .capture_done(capture_done), .capture_cnt(capture_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wen"}, mem_wen, 0);
    chk({tag, "_waddr"}, mem_waddr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, capture_busy, 0);
    chk({tag, "_done"}, capture_done, 0);
    chk({tag, "_cnt"}, capture_cnt, 0);
  endtask

  // one clock: drive inputs, advance the model by one sample slot, compare registered outputs
  task automatic cyc(input logic s, input logic a, input logic v, input logic st,
                     input logic [1:0] len, input logic [DW-1:0] d);
    capture_start = s; capture_again = a; adc_valid = v;
    self_test_mode = st; pkt_data_length = len; adc_data = d;
    @(posedge clk);
    e_wen = 0;
    if (m_busy) begin
      if (v) begin
        e_wen = 1; e_addr = m_n; e_data = st ? DW'(m_n) : d;
        m_n++;
        if (m_n == m_depth) begin m_busy = 0; m_done = 1; m_cnt = (m_cnt + 1) % 256; end
      end
    end else if (s) begin
      m_depth = 216 << len; m_busy = 1; m_n = 0; m_done = 0;
    end else if (a && m_done) begin
      m_busy = 1; m_n = 0; m_done = 0;
    end
    #1;
    chk("wen", mem_wen, e_wen);
    if (e_wen) begin
      chk("waddr", mem_waddr, e_addr);
      chk("wdata", mem_wdata, e_data);
    end
    chk("busy", capture_busy, m_busy);
    chk("done", capture_done, m_done);
    chk("cnt", capture_cnt, m_cnt);
    if (mem_wen === 1'b1) wr_cnt++;
  endtask

  task automatic kick(input logic s, input logic a, input logic [1:0] len, input logic st);
    wr_cnt = 0;
    cyc(s, a, 1'($urandom_range(0, 1)), st, len, DW'($urandom));
  endtask

  // vm: 0 valid always, 1 toggle, 2 random; sm: 0/1 fixed self-test, 2 random per sample
  task automatic run(input int vm, input int sm, input bit jitter, input int pulse_at);
    for (int i = 0; i < 4000 && m_busy; i++) begin
      logic v, st;
      logic [1:0] l;
      v  = vm == 0 ? 1'b1 : vm == 1 ? 1'(i % 2 == 0) : 1'($urandom_range(0, 1));
      st = sm == 2 ? 1'($urandom_range(0, 1)) : 1'(sm == 1);
      l  = jitter ? 2'($urandom_range(0, 3)) : pkt_data_length;
      cyc(1'(i == pulse_at), 1'(i == pulse_at), v, st, l, DW'($urandom));
    end
    chk("done_reached", capture_done, 1);
  endtask

  initial begin
    #1;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rstn = 1;
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, DW'($urandom));
    chk("idle_no_write", wr_cnt, 0);
    kick(1, 0, 2'b00, 1); run(0, 1, 0, -1);
    chk("ramp_216", wr_cnt, 216);
    kick(1, 0, 2'b11, 0); run(1, 0, 0, -1);
    chk("toggle_1728", wr_cnt, 1728);
    kick(1, 0, 2'b01, 0); run(2, 2, 0, -1);
    chk("len01_432", wr_cnt, 432);
    kick(0, 1, 2'b00, 0); run(2, 2, 1, -1);
    chk("again_reuse_432", wr_cnt, 432);
    kick(1, 0, 2'b00, 0); run(0, 0, 0, -1);
    chk("start_relatch_216", wr_cnt, 216);
    kick(1, 1, 2'b10, 0); run(2, 0, 0, -1);
    chk("start_wins_864", wr_cnt, 864);
    kick(1, 0, 2'b00, 1); run(0, 2, 1, 50);
    chk("midcap_pulse_216", wr_cnt, 216);
    chk("midcap_cnt_once", capture_cnt, 7);
    kick(1, 0, 2'b00, 0);
    for (int i = 0; i < 500 && wr_cnt < 100; i++) cyc(0, 0, 1, 0, 0, DW'($urandom));
    chk("pre_abort_writes", wr_cnt, 100);
    rstn = 0;
    m_busy = 0; m_done = 0; m_cnt = 0; m_depth = 216; m_n = 0;
    #1;
    chk_reset_vals("abort");
    @(posedge clk); @(posedge clk); #1;
    chk("abort_hold_wen", mem_wen, 0);
    rstn = 1;
    wr_cnt = 0;
    for (int i = 0; i < 20; i++) cyc(0, 1'(i == 5), 1, 0, 2'($urandom_range(0, 3)), DW'($urandom));
    chk("post_abort_idle", wr_cnt, 0);
    kick(1, 0, 2'b00, 1); run(0, 1, 0, -1);
    chk("post_abort_216", wr_cnt, 216);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
